// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a memory-mapped UART over the UIBI bus.
// Initialises BAUD/CTRL, then per byte polls STATUS until idle and writes TXDATA.
module uart_tx_sched #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] BAUD_DIV  = 32'd434,
    parameter int          TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              bus_req,
    output logic              bus_wen,
    output logic [31:0]       bus_addr,
    output logic [31:0]       bus_dat_o,
    input  logic [31:0]       bus_dat_i,
    input  logic              bus_ready,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic              err,
    output logic [2:0]        dbg_state
);
    // Bus handshake: a request (bus_req with wen/addr/dat_o) is held unchanged until
    // the cycle bus_ready=1; bus_req then drops for at least one cycle. bus_ready
    // seen while bus_req=0 is meaningless and ignored.

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_INIT_BAUD, S_INIT_CTRL, S_IDLE, S_POLL, S_SEND, S_ACK
    } state_t;

    state_t          state, state_d;
    logic            bus_req_d, bus_wen_d, err_d;
    logic [31:0]     bus_addr_d, bus_dat_d;
    logic [2:0]      grant_d, last_grant, last_d, rr_win;
    logic [7:0]      byte_q, byte_d;
    logic [CW-1:0]   to_cnt, cnt_d;
    logic            rr_hit, done, expired;
    logic [64:0]     txn;

    // {wen, addr, data} of the bus transaction a given state performs
    function automatic logic [64:0] txn_of(state_t s, logic [7:0] b);
        case (s)
            S_INIT_BAUD: return {1'b1, BASE_ADDR + 32'h8, BAUD_DIV};
            S_INIT_CTRL: return {1'b1, BASE_ADDR + 32'h0, 32'h1};
            S_POLL:      return {1'b0, BASE_ADDR + 32'h4, 32'h0};
            S_SEND:      return {1'b1, BASE_ADDR + 32'hC, {24'b0, b}};
            default:     return '0;
        endcase
    endfunction

    // Search begins one past the last served requester
    always_comb begin
        rr_hit = 1'b0;
        rr_win = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            if (!rr_hit && req_valid[(int'(last_grant) + k) % NREQ]) begin
                rr_hit = 1'b1;
                rr_win = 3'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d    = state;
        bus_req_d  = bus_req;
        bus_wen_d  = bus_wen;
        bus_addr_d = bus_addr;
        bus_dat_d  = bus_dat_o;
        grant_d    = grant_id;
        byte_d     = byte_q;
        last_d     = last_grant;
        err_d      = err;
        cnt_d      = '0;
        txn        = txn_of(state, byte_q);
        done       = bus_req && bus_ready;
        expired    = bus_req && !bus_ready && (to_cnt == CW'(TIMEOUT - 1));
        if (bus_req && !bus_ready && !expired)
            cnt_d = to_cnt + 1'b1;

        case (state)
            S_INIT_BAUD, S_INIT_CTRL, S_POLL, S_SEND: begin
                if (!bus_req) begin
                    bus_req_d = 1'b1;
                    {bus_wen_d, bus_addr_d, bus_dat_d} = txn;
                end else if (done) begin
                    bus_req_d = 1'b0;
                    case (state)
                        S_INIT_BAUD: state_d = S_INIT_CTRL;
                        S_INIT_CTRL: state_d = S_IDLE;
                        S_POLL:      state_d = bus_dat_i[0] ? S_POLL : S_SEND;
                        default:     state_d = S_ACK;
                    endcase
                end else if (expired) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = (state == S_POLL || state == S_SEND) ? S_IDLE : S_INIT_BAUD;
                end
            end
            S_IDLE: begin
                if (rr_hit) begin
                    grant_d   = rr_win;
                    byte_d    = req_data[{rr_win, 3'b000} +: 8];
                    state_d   = S_POLL;
                    bus_req_d = 1'b1;
                    {bus_wen_d, bus_addr_d, bus_dat_d} = txn_of(S_POLL, 8'h00);
                end
            end
            S_ACK: begin
                last_d  = grant_id;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_BAUD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT_BAUD;
            bus_req    <= 1'b0;
            bus_wen    <= 1'b0;
            bus_addr   <= '0;
            bus_dat_o  <= '0;
            grant_id   <= '0;
            byte_q     <= '0;
            last_grant <= 3'(NREQ - 1);
            err        <= 1'b0;
            to_cnt     <= '0;
        end else begin
            state      <= state_d;
            bus_req    <= bus_req_d;
            bus_wen    <= bus_wen_d;
            bus_addr   <= bus_addr_d;
            bus_dat_o  <= bus_dat_d;
            grant_id   <= grant_d;
            byte_q     <= byte_d;
            last_grant <= last_d;
            err        <= err_d;
            to_cnt     <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = (state == S_ACK) && (grant_id == 3'(i));
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
